// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sipo_pkg;

    // Frame FSM states. PAR is only entered when parity checking is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } sipo_state_t;

    // Default word width.
    localparam int SIPO_W_DEFAULT = 8;

    // Parity mode: 1 = even parity, 0 = odd parity.
    localparam bit SIPO_PAR_EVEN = 1'b1;

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register: captures completed words, valid/ready handshake, sticky overrun.
// Latency: a loaded word is visible on dout/dout_valid one cycle after the load edge.
// Backpressure: a load while a word is held and not being accepted is dropped and flags overrun.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load, word, perr_in completed word (and its parity result) offered this cycle
//   dout, dout_valid    held word and its valid flag
//   dout_ready          consumer accepts the held word
//   overrun, clr_ovr    sticky dropped-word flag and its clear
//   parity_err          parity result registered alongside dout
module sipo_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] word,
    input  logic         perr_in,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         overrun,
    input  logic         clr_ovr,
    output logic         parity_err
);

    logic take;
    logic drop;

    // The holding slot is free if empty or being drained this same cycle.
    assign take = load & (~dout_valid | dout_ready);
    assign drop = load & dout_valid & ~dout_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (take) begin
                dout       <= word;
                parity_err <= perr_in;
                dout_valid <= 1'b1;
            end else if (dout_valid & dout_ready) begin
                dout_valid <= 1'b0;
            end

            // A new drop event beats a simultaneous clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: start-aligned frames of W bits (plus optional parity bit).
// Latency: word valid one cycle after the edge sampling the last data bit (or parity bit).
// Backpressure: valid/ready output; a word completing while one is held unaccepted is dropped (overrun).
//
// Optional feature macro: SIPO_PARITY_EN -- adds a trailing even-parity bit per frame
// checked into parity_err. Without it parity_err is constant 0.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   din, din_en, start     serial bit, bit strobe, frame-start qualifier (with din_en)
//   dout, dout_valid       assembled word and valid flag
//   dout_ready             consumer accepts the word
//   busy                   frame in progress
//   overrun, clr_ovr       sticky dropped-word flag and its clear
//   parity_err             parity result for the current dout word
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int W         = SIPO_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         din,
    input  logic         din_en,
    input  logic         start,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         overrun,
    input  logic         clr_ovr,
    output logic         parity_err
);

    localparam int CW = $clog2(W + 1);

    sipo_state_t  state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sr;
    logic [W-1:0]  sr_shift;

    logic          load;
    logic [W-1:0]  load_word;
    logic          load_perr;

    // Next shift-register value if din is shifted in this cycle.
    assign sr_shift = MSB_FIRST ? {sr[W-2:0], din} : {din, sr[W-1:1]};

`ifdef SIPO_PARITY_EN
    // Word completes on the parity bit; the data word is already sitting in sr.
    assign load      = (state == PAR) & din_en & ~start;
    assign load_word = sr;
    assign load_perr = (^sr) ^ din ^ ~SIPO_PAR_EVEN;
`else
    // Word completes on the W-th data bit; hand over the post-shift value directly.
    assign load      = (state == SHIFT) & din_en & ~start & (cnt == CW'(W - 1));
    assign load_word = sr_shift;
    assign load_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            busy  <= 1'b0;
        end else if (din_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= sr_shift;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr <= sr_shift;
                    if (start) begin
                        // Re-align: this bit becomes bit 1 of a fresh frame.
                        cnt <= CW'(1);
                    end else if (cnt == CW'(W - 1)) begin
                        cnt <= '0;
`ifdef SIPO_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PAR: begin
                    if (start) begin
                        sr    <= sr_shift;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sipo_out_reg #(
        .W (W)
    ) u_out (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .word       (load_word),
        .perr_in    (load_perr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr),
        .parity_err (parity_err)
    );

endmodule
